usb_rx_sampler: RTL

Front end of the USB receive path, directly upstream of the bit-unstuffing stage. It synchronizes the raw D+/D− line pair and recovers bit timing by oversampling at CLKS_PER_BIT clocks per bit, re-aligning on every line edge. It NRZI-decodes each sampled bit and presents it as D_Orig with a one-cycle shift_enable strobe, which connect straight to the unstuffer's inputs of the same names. It also detects SOP (first K after idle) and EOP (SE0, SE0, J).

---
 rtl/usb_rx_pkg.sv | 19 +
 rtl/rx_sync.sv | 26 ++
 rtl/usb_rx_sampler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive sampler.
// Line encodings are {dp, dm}.
package usb_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RECEIVE,
      EOP1,
      EOP2
   } rx_state_t;

   localparam int unsigned CLKS_PER_BIT_DEF = 8;
   localparam int unsigned SAMPLE_POINT_DEF = 3;

   localparam logic [1:0] J_STATE = 2'b10;
   localparam logic [1:0] K_STATE = 2'b01;
   localparam logic [1:0] SE0     = 2'b00;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for one asynchronous line, with a configurable reset level.
module rx_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= RESET_VAL;
         s2_q <= RESET_VAL;
      end else begin
         s1_q <= din;
         s2_q <= s1_q;
      end
   end

   assign dout = s2_q;

endmodule

// File: rtl/usb_rx_sampler.sv
// USB receive front end: line synchronization, edge-aligned bit sampling,
// NRZI decoding and SOP/EOP detection feeding the bit unstuffer.
module usb_rx_sampler
   import usb_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned SAMPLE_POINT = SAMPLE_POINT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic d_plus_in,
   input  logic d_minus_in,
   output logic D_Orig,
   output logic shift_enable,
   output logic receiving,
   output logic eop
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_POINT);

   logic          dp;
   logic          dm;
   logic          dp_prev_q;
   logic [CW-1:0] cnt_q;
   rx_state_t     state_q;
   rx_state_t     state_d;
   logic          prev_level_q;
   logic          prev_level_d;
   logic          d_orig_q;
   logic          d_orig_d;
   logic          shift_en_q;
   logic          shift_en_d;
   logic          receiving_q;
   logic          receiving_d;
   logic          eop_q;
   logic          eop_d;

   logic [1:0]    line;
   logic          edge_det;
   logic          is_se0;
   logic          is_j;
   logic          sample;
   logic          sop;

   rx_sync #(.RESET_VAL(1'b1)) u_sync_dp (
      .clk  (clk),
      .rst  (rst),
      .din  (d_plus_in),
      .dout (dp)
   );

   rx_sync #(.RESET_VAL(1'b0)) u_sync_dm (
      .clk  (clk),
      .rst  (rst),
      .din  (d_minus_in),
      .dout (dm)
   );

   assign line     = {dp, dm};
   assign edge_det = dp ^ dp_prev_q;
   assign is_se0   = (line == SE0);
   assign is_j     = (line == J_STATE);
   // An edge landing on the sample slot re-aligns the counter and suppresses the sample.
   assign sample   = (state_q != IDLE) && (cnt_q == SAMPLE_CNT) && !edge_det;
   assign sop      = (state_q == IDLE) && edge_det && !dp;

   always_ff @(posedge clk) begin
      if (rst) begin
         dp_prev_q <= 1'b1;
         cnt_q     <= '0;
      end else begin
         dp_prev_q <= dp;
         if (state_q == IDLE || edge_det) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (sop) state_d = RECEIVE;
         end
         RECEIVE: begin
            if (sample && is_se0) state_d = EOP1;
         end
         EOP1: begin
            if (sample) state_d = is_se0 ? EOP2 : RECEIVE;
         end
         EOP2: begin
            // J completes the EOP, SE0 keeps waiting, anything else aborts.
            if (sample && !is_se0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      shift_en_d   = sample && !is_se0 && (state_q == RECEIVE || state_q == EOP1);
      eop_d        = sample && is_j && (state_q == EOP2);
      receiving_d  = (state_d != IDLE);
      d_orig_d     = shift_en_d ? (dp == prev_level_q) : d_orig_q;
      prev_level_d = prev_level_q;
      if (sop) begin
         prev_level_d = 1'b1;
      end else if (sample && !is_se0) begin
         prev_level_d = dp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_level_q <= 1'b1;
         d_orig_q     <= 1'b1;
         shift_en_q   <= 1'b0;
         receiving_q  <= 1'b0;
         eop_q        <= 1'b0;
      end else begin
         prev_level_q <= prev_level_d;
         d_orig_q     <= d_orig_d;
         shift_en_q   <= shift_en_d;
         receiving_q  <= receiving_d;
         eop_q        <= eop_d;
      end
   end

   assign D_Orig       = d_orig_q;
   assign shift_enable = shift_en_q;
   assign receiving    = receiving_q;
   assign eop          = eop_q;

endmodule
